// File: rtl/recip_frame_tx.sv
// recip_frame_tx: buffers (N, C_coarse) results in a small FIFO and sends each as an ASCII hex frame to uart_tx.
// Optional RECIP_FRAME_SEQ_EN appends ",SS" (8-bit sequence number) before CR LF.
module recip_frame_tx #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned DROP_CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          res_valid,
  input  logic [23:0]                   res_n,
  input  logic [23:0]                   res_coarse,
  input  logic                          tx_busy,
  output logic [7:0]                    tx_data,
  output logic                          tx_start,
  output logic                          res_drop,
  output logic [DROP_CNT_WIDTH-1:0]     drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_active
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned IW = 5;
`ifdef RECIP_FRAME_SEQ_EN
  localparam int unsigned LAST = 19;
`else
  localparam int unsigned LAST = 16;
`endif

  typedef struct packed {
`ifdef RECIP_FRAME_SEQ_EN
    logic [7:0]  seq;
`endif
    logic [23:0] n;
    logic [23:0] c;
  } entry_t;

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

  entry_t          mem [FIFO_DEPTH];
  entry_t          in_c;
  entry_t          cur;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [IW-1:0]   byte_idx;
  state_t          state;
  logic            tx_busy_d;
  logic            empty_c;
  logic            full_c;
  logic            pop_c;
  logic            push_c;
  logic            drop_c;
`ifdef RECIP_FRAME_SEQ_EN
  logic [7:0]      seq;
`endif

  // Pop is resolved first, so a full FIFO still accepts a push in the pop cycle.
  assign empty_c = (fifo_level == '0);
  assign full_c  = (fifo_level == LW'(FIFO_DEPTH));
  assign pop_c   = (state == IDLE) && !empty_c;
  assign push_c  = res_valid && (!full_c || pop_c);
  assign drop_c  = res_valid && !push_c;

  always_comb begin
    in_c   = '0;
    in_c.n = res_n;
    in_c.c = res_coarse;
`ifdef RECIP_FRAME_SEQ_EN
    in_c.seq = seq;
`endif
  end

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

  // Byte idx of the frame built from entry e.
  function automatic logic [7:0] frame_char(input entry_t e, input logic [IW-1:0] idx);
    logic [7:0] ch;
    ch = 8'h00;
    case (idx)
      5'd0:  ch = 8'h52;
      5'd1:  ch = 8'h3D;
      5'd2:  ch = hex_char(e.n[23:20]);
      5'd3:  ch = hex_char(e.n[19:16]);
      5'd4:  ch = hex_char(e.n[15:12]);
      5'd5:  ch = hex_char(e.n[11:8]);
      5'd6:  ch = hex_char(e.n[7:4]);
      5'd7:  ch = hex_char(e.n[3:0]);
      5'd8:  ch = 8'h2C;
      5'd9:  ch = hex_char(e.c[23:20]);
      5'd10: ch = hex_char(e.c[19:16]);
      5'd11: ch = hex_char(e.c[15:12]);
      5'd12: ch = hex_char(e.c[11:8]);
      5'd13: ch = hex_char(e.c[7:4]);
      5'd14: ch = hex_char(e.c[3:0]);
`ifdef RECIP_FRAME_SEQ_EN
      5'd15: ch = 8'h2C;
      5'd16: ch = hex_char(e.seq[7:4]);
      5'd17: ch = hex_char(e.seq[3:0]);
      5'd18: ch = 8'h0D;
      5'd19: ch = 8'h0A;
`else
      5'd15: ch = 8'h0D;
      5'd16: ch = 8'h0A;
`endif
      default: ch = 8'h00;
    endcase
    return ch;
  endfunction

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= in_c;
  end

  // FIFO pointers, level, drop reporting and sequence numbering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      res_drop   <= 1'b0;
      drop_cnt   <= '0;
      tx_busy_d  <= 1'b0;
`ifdef RECIP_FRAME_SEQ_EN
      seq        <= '0;
`endif
    end else begin
      tx_busy_d <= tx_busy;
      res_drop  <= drop_c;
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      if (push_c && !pop_c)      fifo_level <= fifo_level + LW'(1);
      else if (pop_c && !push_c) fifo_level <= fifo_level - LW'(1);
      if (drop_c && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
`ifdef RECIP_FRAME_SEQ_EN
      if (push_c) seq <= seq + 8'd1;
`endif
    end
  end

  // Frame sequencer: one byte per LOAD/START/WAIT round trip.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur          <= '0;
      byte_idx     <= '0;
      tx_data      <= 8'h00;
      tx_start     <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty_c) begin
            cur          <= mem[rd_ptr];
            byte_idx     <= '0;
            frame_active <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          tx_data <= frame_char(cur, byte_idx);
          state   <= START;
        end
        START: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (tx_busy_d && !tx_busy) begin
            if (byte_idx == IW'(LAST)) begin
              frame_active <= 1'b0;
              state        <= IDLE;
            end else begin
              byte_idx <= byte_idx + IW'(1);
              state    <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recip_frame_tx.sv
// Bench for recip_frame_tx: uart_tx busy model, byte-level frame reference model, randomized bursts.
// Honours RECIP_FRAME_SEQ_EN when defined for the whole build.
module tb_recip_frame_tx;

  localparam int unsigned DEPTH   = 4;
  localparam int          BUSY_CYC = 10;
  localparam int          BUDGET  = 20000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        res_valid;
  logic [23:0] res_n;
  logic [23:0] res_coarse;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        res_drop;
  logic [7:0]  drop_cnt;
  logic [2:0]  fifo_level;
  logic        frame_active;

  recip_frame_tx #(.FIFO_DEPTH(DEPTH), .DROP_CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_n(res_n),
    .res_coarse(res_coarse), .tx_busy(tx_busy), .tx_data(tx_data),
    .tx_start(tx_start), .res_drop(res_drop), .drop_cnt(drop_cnt),
    .fifo_level(fifo_level), .frame_active(frame_active)
  );

  always #10 clk = ~clk;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         gap_q[$];
  logic [7:0] exp_q[$];
  int         drop_seen = 0;
  int         busy_cnt = 0;
  int         pos = 0;
  int         fall_cyc = 0;
  bit         fall_valid = 1'b0;
  bit         prev_busy;
  bit         hold_busy = 1'b0;
  logic [7:0] seq_m = 8'h00;
  int         last_rv_cyc = 0;
  int         peak = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: captures the byte on tx_start, then stays busy for BUSY_CYC cycles.
  always @(negedge clk) begin
    prev_busy = tx_busy;
    if (busy_cnt != 0) busy_cnt = busy_cnt - 1;
    if (!frame_active) pos = 0;
    if (tx_start) begin
      rx_q.push_back(tx_data);
      start_q.push_back(cyc);
      if (pos != 0 && fall_valid) gap_q.push_back(cyc - fall_cyc);
      pos = pos + 1;
      fall_valid = 1'b0;
      busy_cnt = BUSY_CYC;
    end
    tx_busy = hold_busy || (busy_cnt != 0);
    if (prev_busy && !tx_busy) begin
      fall_valid = 1'b1;
      fall_cyc = cyc;
    end
    if (res_drop) drop_seen = drop_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks = n_checks + 1;
    if (got !== want) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] v);
    if (v < 4'd10) return 8'h30 + 8'(v);
    return 8'h41 + 8'(v) - 8'd10;
  endfunction

  // Reference frame for one accepted result, appended to the expected byte stream.
  task automatic exp_frame(input logic [23:0] n, input logic [23:0] c);
    exp_q.push_back(8'h52);
    exp_q.push_back(8'h3D);
    for (int i = 5; i >= 0; i--) exp_q.push_back(hexc(4'(n >> (4 * i))));
    exp_q.push_back(8'h2C);
    for (int i = 5; i >= 0; i--) exp_q.push_back(hexc(4'(c >> (4 * i))));
`ifdef RECIP_FRAME_SEQ_EN
    exp_q.push_back(8'h2C);
    exp_q.push_back(hexc(seq_m[7:4]));
    exp_q.push_back(hexc(seq_m[3:0]));
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic tick();
    @(negedge clk);
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
  endtask

  task automatic send(input logic [23:0] n, input logic [23:0] c, input bit accept);
    @(negedge clk);
    res_valid = 1'b1;
    res_n = n;
    res_coarse = c;
    last_rv_cyc = cyc + 1;
    if (accept) begin
      exp_frame(n, c);
      seq_m = seq_m + 8'd1;
    end
    tick();
    res_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seq_m = 8'h00;
    exp_q.delete();
  endtask

  task automatic wait_drain(input string tag, input int base);
    int n = 0;
    while (!((rx_q.size() - base) >= exp_q.size() && !frame_active && fifo_level == 3'd0)
           && n < BUDGET) begin
      @(negedge clk);
      n = n + 1;
    end
    check({tag, "_drain"}, 32'(n < BUDGET), 32'd1);
  endtask

  task automatic compare_rx(input string tag, input int base);
    check({tag, "_nbytes"}, rx_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && (base + i) < rx_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(rx_q[base + i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  initial begin
    int base;
    int dbase;
    int n;
    rst_n = 1'b0;
    res_valid = 1'b0;
    res_n = '0;
    res_coarse = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_tx_start", 32'(tx_start), 32'h0);
    check("rst_res_drop", 32'(res_drop), 32'h0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    check("rst_fifo_level", 32'(fifo_level), 32'h0);
    check("rst_frame_active", 32'(frame_active), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single result with first-byte latency.
    base = rx_q.size();
    n = start_q.size();
    send(24'h000640, 24'h0186A0, 1'b1);
    wait_drain("single", base);
    if (start_q.size() > n) check("single_latency", start_q[n] - last_rv_cyc, 3);
    else check("single_latency_seen", 32'(start_q.size()), 32'(n + 1));
    compare_rx("single", base);

    // Burst of four, two cycles apart.
    base = rx_q.size();
    dbase = drop_seen;
    peak = 0;
    send(24'h111111, 24'h222222, 1'b1);
    send(24'h333333, 24'h444444, 1'b1);
    send(24'h555555, 24'h666666, 1'b1);
    send(24'h777777, 24'h888888, 1'b1);
    tick();
    tick();
    check("burst_peak", peak, 3);
    wait_drain("burst", base);
    check("burst_drops", drop_seen - dbase, 0);
    compare_rx("burst", base);

    // Overflow with uart held busy: frame regs plus FIFO hold five results.
    do_reset();
    hold_busy = 1'b1;
    base = rx_q.size();
    dbase = drop_seen;
    for (int i = 0; i < 7; i++) begin
      send(24'(32'h100000 + 32'h010101 * i), 24'(32'hA00000 + i), i < int'(DEPTH) + 1);
      check($sformatf("ovf_drop%0d", i), 32'(res_drop), 32'(i >= int'(DEPTH) + 1));
    end
    tick();
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
    check("ovf_drop_pulses", drop_seen - dbase, 2);
    check("ovf_frame_active", 32'(frame_active), 32'd1);
    hold_busy = 1'b0;
    wait_drain("ovf", base);
    compare_rx("ovf", base);

    // Drop counter saturation.
    do_reset();
    hold_busy = 1'b1;
    dbase = drop_seen;
    for (int i = 0; i < int'(DEPTH) + 1; i++) send(24'(i), 24'(i), 1'b1);
    for (int i = 0; i < 300; i++) send(24'($urandom), 24'($urandom), 1'b0);
    tick();
    check("sat_drop_cnt", 32'(drop_cnt), 32'hFF);
    check("sat_drop_pulses", drop_seen - dbase, 300);
    check("sat_level", 32'(fifo_level), 32'd4);
    do_reset();
    hold_busy = 1'b0;
    repeat (5) tick();

    // Reset after byte 5 of a frame, with more results queued.
    base = rx_q.size();
    send(24'h123456, 24'h654321, 1'b1);
    send(24'h0A0B0C, 24'h0D0E0F, 1'b1);
    send(24'hC0FFEE, 24'hBEEF00, 1'b1);
    n = 0;
    while ((rx_q.size() - base) < 5 && n < BUDGET) begin
      @(negedge clk);
      n = n + 1;
    end
    check("mid_reached_b5", 32'(n < BUDGET), 32'd1);
    do_reset();
    check("mid_tx_start", 32'(tx_start), 32'h0);
    check("mid_tx_data", 32'(tx_data), 32'h0);
    check("mid_fifo_level", 32'(fifo_level), 32'h0);
    check("mid_frame_active", 32'(frame_active), 32'h0);
    check("mid_res_drop", 32'(res_drop), 32'h0);
    check("mid_drop_cnt", 32'(drop_cnt), 32'h0);
    repeat (200) tick();
    check("mid_no_more_bytes", rx_q.size() - base, 5);

    // Fresh frame after the reset, all hex letters.
    base = rx_q.size();
    send(24'hABCDEF, 24'hFEDCBA, 1'b1);
    wait_drain("hex", base);
    compare_rx("hex", base);

    // Random bursts that fit in frame regs plus FIFO.
    for (int r = 0; r < 6; r++) begin
      int cnt;
      base = rx_q.size();
      dbase = drop_seen;
      cnt = int'($urandom_range(1, DEPTH + 1));
      for (int i = 0; i < cnt; i++) begin
        send(24'($urandom), 24'($urandom), 1'b1);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_drain($sformatf("rnd%0d", r), base);
      check($sformatf("rnd%0d_drops", r), drop_seen - dbase, 0);
      compare_rx($sformatf("rnd%0d", r), base);
    end

    check("gap_samples", 32'(gap_q.size() > 0), 32'd1);
    foreach (gap_q[i]) check($sformatf("gap%0d", i), gap_q[i], 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
